// File: rtl/accel_mem_port.sv
// Accelerator-side memory initiator: queues read/write requests and replays them
// on the shared memory's accelerator port, retrying each head until the CPU yields.
module accel_mem_port #(
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int LINE_W       = 512,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    input  logic                          cpu_busy,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wrt_data,
    output logic                          mem_wrt_en,
    output logic                          mem_rd_en,
    input  logic [LINE_W-1:0]             mem_rd_data,
    output logic                          rsp_valid,
    output logic [LINE_W-1:0]             rsp_rdata,
    output logic [ADDR_W-1:0]             rsp_addr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          starve
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    req_t              fifo_mem [FIFO_DEPTH];
    req_t              head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              nonempty;
    logic              full;
    logic              push;
    logic              grant;
    logic              stall;
    logic [7:0]        stall_cnt;
    logic [7:0]        stall_cnt_nxt;
    logic              rd_vld;
    logic [ADDR_W-1:0] rd_addr;

    // IDLE/ISSUE/STALL are fully implied by occupancy and cpu_busy, so no
    // separate state register is kept: stall = STALL, grant = ISSUE.
    assign head      = fifo_mem[rd_ptr];
    assign nonempty  = (fifo_count != '0);
    assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign req_ready = !full;
    assign push      = req_valid && req_ready;
    assign grant     = nonempty && !cpu_busy;
    assign stall     = nonempty && cpu_busy;

    assign mem_addr     = head.addr;
    assign mem_wrt_data = head.wdata;
    assign mem_wrt_en   = nonempty && head.we;
    assign mem_rd_en    = nonempty && !head.we;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{we: req_we, addr: req_addr, wdata: req_wdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (grant)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, grant})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // starve looks at the updated count so it rises on the cycle after the
    // STARVE_LIMIT-th stall and drops on the cycle after a grant.
    always_comb begin
        stall_cnt_nxt = stall_cnt;
        if (grant || !nonempty)
            stall_cnt_nxt = '0;
        else if (stall && stall_cnt != 8'hFF)
            stall_cnt_nxt = stall_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            starve    <= 1'b0;
        end else begin
            stall_cnt <= stall_cnt_nxt;
            starve    <= (stall_cnt_nxt >= 8'(STARVE_LIMIT));
        end
    end

    // Stage 1 marks a read granted last cycle; its line is on mem_rd_data now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld    <= 1'b0;
            rd_addr   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_addr  <= '0;
        end else begin
            rd_vld    <= grant && !head.we;
            rd_addr   <= head.addr;
            rsp_valid <= rd_vld;
            if (rd_vld) begin
                rsp_rdata <= mem_rd_data;
                rsp_addr  <= rd_addr;
            end
        end
    end

endmodule

// File: tb/tb_accel_mem_port.sv
// Directed bench for accel_mem_port: cycle tables for basic traffic plus
// sequences for backpressure, starvation, mid-flight reset and a mixed stream.
module tb_accel_mem_port;
    localparam int FD = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LW = 512;
    localparam int SL = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [AW-1:0]         req_addr;
    logic [DW-1:0]         req_wdata;
    logic                  cpu_busy;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wrt_data;
    logic                  mem_wrt_en;
    logic                  mem_rd_en;
    logic [LW-1:0]         mem_rd_data;
    logic                  rsp_valid;
    logic [LW-1:0]         rsp_rdata;
    logic [AW-1:0]         rsp_addr;
    logic [$clog2(FD):0]   fifo_count;
    logic                  starve;

    accel_mem_port #(.FIFO_DEPTH(FD), .ADDR_W(AW), .DATA_W(DW), .LINE_W(LW),
                     .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .cpu_busy(cpu_busy), .mem_addr(mem_addr), .mem_wrt_data(mem_wrt_data),
        .mem_wrt_en(mem_wrt_en), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
        .fifo_count(fifo_count), .starve(starve)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a, input logic [DW-1:0] w);
        line_of = {{15{w ^ {16'h0, a}}}, w};
    endfunction

    // Memory model: one-cycle read latency, writes land at the granting edge.
    logic [DW-1:0] mem [0:1023] = '{default: '0};
    always @(posedge clk) begin
        if (mem_wrt_en && !cpu_busy)
            mem[mem_addr[9:0]] <= mem_wrt_data;
        if (mem_rd_en && !cpu_busy)
            mem_rd_data <= line_of(mem_addr, mem[mem_addr[9:0]]);
        else
            mem_rd_data <= {16{$urandom()}};
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          v;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          b;
        logic          e_ready;
        int            e_cnt;
        logic          e_rd;
        logic          e_wr;
        logic [AW-1:0] e_maddr;
        logic          e_rsp;
        logic [AW-1:0] e_raddr;
        logic [DW-1:0] e_word;
        logic          e_starve;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic we, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic b, input logic rdy,
                                input int cnt, input logic rd, input logic wr,
                                input logic [AW-1:0] ma, input logic rsp,
                                input logic [AW-1:0] ra, input logic [DW-1:0] rw);
        vec_t x;
        x.v = v; x.we = we; x.a = a; x.d = d; x.b = b;
        x.e_ready = rdy; x.e_cnt = cnt; x.e_rd = rd; x.e_wr = wr; x.e_maddr = ma;
        x.e_rsp = rsp; x.e_raddr = ra; x.e_word = rw; x.e_starve = 1'b0;
        return x;
    endfunction

    task automatic drv(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic b);
        req_valid = v; req_we = we; req_addr = a; req_wdata = d; cpu_busy = b;
    endtask

    task automatic check_vec(input string tag, input vec_t x);
        chk({tag, ".ready"}, LW'(req_ready), LW'(x.e_ready));
        chk({tag, ".count"}, LW'(fifo_count), LW'(x.e_cnt));
        chk({tag, ".rd_en"}, LW'(mem_rd_en), LW'(x.e_rd));
        chk({tag, ".wrt_en"}, LW'(mem_wrt_en), LW'(x.e_wr));
        if (x.e_rd || x.e_wr)
            chk({tag, ".mem_addr"}, LW'(mem_addr), LW'(x.e_maddr));
        chk({tag, ".rsp_valid"}, LW'(rsp_valid), LW'(x.e_rsp));
        if (x.e_rsp) begin
            chk({tag, ".rsp_addr"}, LW'(rsp_addr), LW'(x.e_raddr));
            chk({tag, ".rsp_rdata"}, rsp_rdata, line_of(x.e_raddr, x.e_word));
        end
        chk({tag, ".starve"}, LW'(starve), LW'(x.e_starve));
    endtask

    task automatic cyc(input string tag, input vec_t x);
        @(negedge clk);
        drv(x.v, x.we, x.a, x.d, x.b);
        #1;
        check_vec(tag, x);
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    vec_t tbl [14];
    req_t stream [10];
    req_t exp_iss [$];
    req_t exp_rsp [$];
    logic [DW-1:0] ref_mem [int];

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t x;
        req_t r;
        int idx, n_iss, n_rsp;

        // write then read-back, then a read stalled three cycles by the CPU
        tbl[0]  = mk(1, 1, 16'h10, 32'hDEADBEEF, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 16'h10, 0, 0, 1, 1, 0, 1, 16'h10, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 16'h10, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 16'h10, 32'hDEADBEEF);
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 16'h40, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 1, 1, 1, 1, 0, 16'h40, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 1, 1, 1, 1, 0, 16'h40, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 1, 1, 1, 1, 0, 16'h40, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 16'h40, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 16'h40, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        stream[0] = '{1'b1, 16'h100, 32'h11111111};
        stream[1] = '{1'b0, 16'h100, 32'h0};
        stream[2] = '{1'b1, 16'h101, 32'h22222222};
        stream[3] = '{1'b0, 16'h102, 32'h0};
        stream[4] = '{1'b1, 16'h100, 32'h33333333};
        stream[5] = '{1'b0, 16'h100, 32'h0};
        stream[6] = '{1'b0, 16'h101, 32'h0};
        stream[7] = '{1'b1, 16'h102, 32'h44444444};
        stream[8] = '{1'b0, 16'h102, 32'h0};
        stream[9] = '{1'b0, 16'h103, 32'h0};

        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        check_vec("reset", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        chk("reset.rsp_rdata", rsp_rdata, '0);
        chk("reset.rsp_addr", LW'(rsp_addr), '0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            cyc($sformatf("tbl%0d", i), tbl[i]);

        // fill under CPU pressure, hold a 5th request, then drain back-to-back
        cyc("full0", mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        cyc("full1", mk(1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0));
        cyc("full2", mk(1, 0, 2, 0, 1, 1, 2, 1, 0, 0, 0, 0, 0));
        cyc("full3", mk(1, 0, 3, 0, 1, 1, 3, 1, 0, 0, 0, 0, 0));
        cyc("full4", mk(1, 0, 4, 0, 1, 0, 4, 1, 0, 0, 0, 0, 0));
        cyc("full5", mk(1, 0, 4, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0));
        cyc("full6", mk(1, 0, 4, 0, 0, 1, 3, 1, 0, 1, 0, 0, 0));
        cyc("full7", mk(0, 0, 0, 0, 0, 1, 3, 1, 0, 2, 1, 0, 0));
        cyc("full8", mk(0, 0, 0, 0, 0, 1, 2, 1, 0, 3, 1, 1, 0));
        cyc("full9", mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 4, 1, 2, 0));
        cyc("full10", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 3, 0));
        cyc("full11", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 4, 0));
        cyc("full12", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

        // starvation: 20 stalled cycles, starve visible after the 16th
        cyc("stv0", mk(1, 0, 16'h80, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 20; k++) begin
            x = mk(0, 0, 0, 0, 1, 1, 1, 1, 0, 16'h80, 0, 0, 0);
            x.e_starve = (k >= 17);
            cyc($sformatf("stv%0d", k), x);
        end
        x = mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 16'h80, 0, 0, 0);
        x.e_starve = 1'b1;
        cyc("stv21", x);
        cyc("stv22", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        cyc("stv23", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 16'h80, 0));

        // reset with two reads in flight and one queued
        cyc("rst0", mk(1, 0, 16'h90, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        cyc("rst1", mk(1, 0, 16'h91, 0, 0, 1, 1, 1, 0, 16'h90, 0, 0, 0));
        cyc("rst2", mk(1, 0, 16'h92, 0, 0, 1, 1, 1, 0, 16'h91, 0, 0, 0));
        @(negedge clk);
        drv(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check_vec("rst3", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        chk("rst3.rsp_addr", LW'(rsp_addr), '0);
        chk("rst3.rsp_rdata", rsp_rdata, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++)
            cyc($sformatf("rstq%0d", k), mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

        // mixed stream against an in-order reference model
        idx = 0; n_iss = 0; n_rsp = 0;
        for (int c = 0; c < 400 && !(n_iss == 10 && n_rsp == 6); c++) begin
            @(negedge clk);
            if (idx < 10)
                drv(1, stream[idx].we, stream[idx].a, stream[idx].d, 1'($urandom_range(0, 1)));
            else
                drv(0, 0, 0, 0, 1'($urandom_range(0, 1)));
            #1;
            if ((mem_rd_en || mem_wrt_en) && !cpu_busy) begin
                if (exp_iss.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mix.extra_issue got addr %0h want none", mem_addr);
                end else begin
                    r = exp_iss.pop_front();
                    chk($sformatf("mix.iss%0d.we", n_iss), LW'(mem_wrt_en), LW'(r.we));
                    chk($sformatf("mix.iss%0d.addr", n_iss), LW'(mem_addr), LW'(r.a));
                    if (r.we)
                        chk($sformatf("mix.iss%0d.wdata", n_iss), LW'(mem_wrt_data), LW'(r.d));
                end
                n_iss++;
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mix.extra_rsp got addr %0h want none", rsp_addr);
                end else begin
                    r = exp_rsp.pop_front();
                    chk($sformatf("mix.rsp%0d.addr", n_rsp), LW'(rsp_addr), LW'(r.a));
                    chk($sformatf("mix.rsp%0d.data", n_rsp), rsp_rdata, line_of(r.a, r.d));
                end
                n_rsp++;
            end
            if (req_valid && req_ready) begin
                r = stream[idx];
                exp_iss.push_back(r);
                if (r.we)
                    ref_mem[int'(r.a)] = r.d;
                else begin
                    r.d = ref_mem.exists(int'(r.a)) ? ref_mem[int'(r.a)] : '0;
                    exp_rsp.push_back(r);
                end
                idx++;
            end
        end
        chk("mix.accepted", LW'(idx), LW'(10));
        chk("mix.issued", LW'(n_iss), LW'(10));
        chk("mix.responses", LW'(n_rsp), LW'(6));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/accel_mem_port.md
Name: accel_mem_port

Overview:
Accelerator-side initiator for the shared data memory. The memory arbiter gives the CPU priority whenever the CPU reads or writes, so accelerator accesses can be lost on any cycle. This block queues accelerator read/write requests in a FIFO and presents them to the memory's accelerator port. It holds each request until it wins a cycle, then returns 512-bit read lines in order with a valid pulse.

Parameters:
FIFO_DEPTH, 4, request FIFO entries (power of 2, >=2)
ADDR_W, 16, memory address width
DATA_W, 32, write data width
LINE_W, 512, read line width
STARVE_LIMIT, 16, consecutive lost cycles before starve asserts (<=255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  accelerator request valid
req_ready  out  1  FIFO can accept; equals !full
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data (ignored for reads)
cpu_busy  in  1  CPU owns memory this cycle (cpu_wrt_en|cpu_rd_en)
mem_addr  out  ADDR_W  to accelerator address port
mem_wrt_data  out  DATA_W  to accelerator write-data port
mem_wrt_en  out  1  accelerator write enable
mem_rd_en  out  1  accelerator read enable
mem_rd_data  in  LINE_W  memory read line
rsp_valid  out  1  one-cycle pulse, read line returned
rsp_rdata  out  LINE_W  returned line
rsp_addr  out  ADDR_W  address of returned read
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
starve  out  1  accelerator starved by CPU

Behaviour:
- Reset (async, rst_n=0): FIFO pointers, fifo_count, read pipe, stall counter and rsp registers cleared. rsp_valid=0, starve=0, mem_wrt_en=0, mem_rd_en=0, req_ready=1, rsp_rdata=0, rsp_addr=0. Reset mid-operation drops all queued requests and in-flight reads; no response is emitted after release.
- FIFO: circular buffer of {we, addr, wdata}.
  - Push when req_valid & req_ready.
  - Full: req_ready=0; the requester must hold req_* stable.
  - An entry pushed into an empty FIFO becomes the head next cycle; there is no same-cycle bypass.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
- States: IDLE (empty), ISSUE (head presented, cpu_busy=0), STALL (head presented, cpu_busy=1).
  - IDLE->ISSUE/STALL when count becomes nonzero.
  - ISSUE pops the head; stays ISSUE/STALL if entries remain, else goes to IDLE.
  - STALL->ISSUE on the first cycle with cpu_busy=0.
- Presentation is combinational from the FIFO head:
  - mem_addr=head.addr, mem_wrt_data=head.wdata.
  - mem_wrt_en = nonempty & head.we; mem_rd_en = nonempty & !head.we.
  - Outputs stay stable through STALL.
- Grant = nonempty & !cpu_busy. On grant the head pops, giving one request per cycle maximum.
- Read latency: memory returns the line in cycle N+1 for a read granted in cycle N.
  - The block captures mem_rd_data at the end of N+1 into rsp_rdata.
  - rsp_valid is high in cycle N+2 only, with rsp_addr equal to the granted address.
  - A 2-stage {valid, addr} pipe tracks in-flight reads, so back-to-back reads give back-to-back rsp_valid.
  - cpu_busy in N+1 does not affect capture.
- Responses come back in request order. There is no response backpressure; the accelerator must accept every rsp_valid.
- Writes complete on grant and produce no response. A read queued after a write to the same address returns the new data, because the FIFO issues in order.
- Starvation:
  - 8-bit saturating stall_cnt increments each STALL cycle and clears on grant or when empty.
  - starve = (stall_cnt >= STARVE_LIMIT), registered.
  - starve clears the cycle after a grant.
- fifo_count is registered and updated on push/pop.

Test Plan:
1. Push write(0x0010, 0xDEADBEEF) then read(0x0010), cpu_busy=0 -> mem_wrt_en one cycle, then mem_rd_en one cycle; rsp_valid 2 cycles after read grant, rsp_rdata[31:0]=0xDEADBEEF, rsp_addr=0x0010.
2. Read(0x0040) queued, cpu_busy=1 for 3 cycles -> mem_rd_en=1, mem_addr=0x0040 stable for 3 cycles, fifo_count stays 1; grant on cycle 4, rsp_valid at cycle 6.
3. Push 4 reads (0x0..0x3) with cpu_busy=1 -> req_ready=0 after the 4th, fifo_count=4, 5th request held; drop cpu_busy -> 4 consecutive grants, 4 consecutive rsp_valid pulses with rsp_addr 0x0,0x1,0x2,0x3; then 5th accepted.
4. Head valid, cpu_busy=1 for 20 cycles -> starve rises after 16 stall cycles (registered), stays high; grant on cycle 21, starve=0 the next cycle.
5. Two reads granted, then rst_n=0 in the cycle after the second grant -> rsp_valid=0 immediately, fifo_count=0, req_ready=1; no rsp_valid after release.
6. Stream 10 mixed requests with random cpu_busy (~50%) -> pointers wrap twice, memory sees the exact request order, read responses match a reference model in order, no request lost or duplicated.
